// File: rtl/sd_110_pattern_gen.sv
// Serial "110" triplet burst generator feeding the 110 toggle detector.
// Tracks a cycle-aligned copy of the detector output in level.
module sd_110_pattern_gen #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] toggles,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic             level,
    output logic [CNT_W-1:0] sent
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        B1   = 3'd1,
        B2   = 3'd2,
        B0   = 3'd3,
        GAP  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   rem;
    logic [CNT_W-1:0]   rem_dec;
    logic [GAP_W-1:0]   gcfg;
    logic [GAP_W-1:0]   gcnt;
    logic               abort_pend;
    logic               abort_eff;
    logic               in_triplet;

    assign rem_dec = rem - CNT_W'(1);

    // Next-state decode; an abort seen on the B0 edge itself also ends the burst.
    always_comb begin
        state_next = state;
        in_triplet = (state == B1) || (state == B2) || (state == B0);
        abort_eff  = abort_pend || (abort && in_triplet);
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (toggles != '0) ? B1 : DONE;
                end
            end
            B1:   state_next = B2;
            B2:   state_next = B0;
            B0: begin
                if ((rem_dec == '0) || abort_eff) begin
                    state_next = DONE;
                end else if (gcfg != '0) begin
                    state_next = GAP;
                end else begin
                    state_next = B1;
                end
            end
            GAP: begin
                if (abort) begin
                    state_next = DONE;
                end else if (gcnt == '0) begin
                    state_next = B1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, datapath and registered Moore outputs (decoded from next state).
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rem        <= '0;
            gcfg       <= '0;
            gcnt       <= '0;
            abort_pend <= 1'b0;
            level      <= 1'b0;
            sent       <= '0;
            out        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state <= state_next;
            out   <= (state_next == B1) || (state_next == B2);
            busy  <= (state_next == B1) || (state_next == B2) ||
                     (state_next == B0) || (state_next == GAP);
            done  <= (state_next == DONE);

            if (in_triplet && abort) begin
                abort_pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        rem        <= toggles;
                        gcfg       <= gap;
                        sent       <= '0;
                        abort_pend <= 1'b0;
                    end
                end
                B0: begin
                    rem   <= rem_dec;
                    sent  <= sent + CNT_W'(1);
                    level <= ~level;
                    if (state_next == GAP) begin
                        gcnt <= gcfg - GAP_W'(1);
                    end
                end
                GAP: begin
                    if (gcnt != '0) begin
                        gcnt <= gcnt - GAP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_110_pattern_gen.sv
// Bench for sd_110_pattern_gen: vector table plus hand sequences, with a
// co-simulated 110 toggle detector compared against level every cycle.
module tb_sd_110_pattern_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] toggles = '0;
    logic [3:0] gap = '0;
    logic       abort = 1'b0;
    logic       out;
    logic       busy;
    logic       done;
    logic       level;
    logic [7:0] sent;

    int n_vec = 0;
    int n_err = 0;

    sd_110_pattern_gen #(.CNT_W(8), .GAP_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .toggles (toggles),
        .gap     (gap),
        .abort   (abort),
        .out     (out),
        .busy    (busy),
        .done    (done),
        .level   (level),
        .sent    (sent)
    );

    always #5 clk = ~clk;

    // Reference 110 toggle detector driven by the generator output.
    logic d1, d2, det;
    always @(posedge clk) begin
        if (rst) begin
            d1  <= 1'b0;
            d2  <= 1'b0;
            det <= 1'b0;
        end else begin
            if (d2 && d1 && !out) det <= ~det;
            d2 <= d1;
            d1 <= out;
        end
    end

    typedef struct {
        logic       rst;
        logic       start;
        logic [7:0] toggles;
        logic [3:0] gap;
        logic       abort;
        logic       eout;
        logic       ebusy;
        logic       edone;
        logic       elevel;
        logic [7:0] esent;
    } vec_t;

    localparam int NV = 12;
    vec_t tbl [0:NV-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("cosim_level", 32'(level), 32'(det));
    endtask

    task automatic chk_all(input string name, input logic eo, input logic eb,
                           input logic ed, input logic el, input logic [7:0] es);
        chk({name, "_out"},   32'(out),   32'(eo));
        chk({name, "_busy"},  32'(busy),  32'(eb));
        chk({name, "_done"},  32'(done),  32'(ed));
        chk({name, "_level"}, 32'(level), 32'(el));
        chk({name, "_sent"},  32'(sent),  32'(es));
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            rst     = tbl[i].rst;
            start   = tbl[i].start;
            toggles = tbl[i].toggles;
            gap     = tbl[i].gap;
            abort   = tbl[i].abort;
            tick();
            chk_all($sformatf("row%0d", i), tbl[i].eout, tbl[i].ebusy,
                    tbl[i].edone, tbl[i].elevel, tbl[i].esent);
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [12:0] exp3;
    logic [5:0]  exp5;

    initial begin
        //             rst  st  tog   gap  ab  out bsy dn  lvl sent
        tbl[0]  = '{1'b1,1'b0,8'd0,4'd0,1'b0,1'b0,1'b0,1'b0,1'b0,8'd0};
        tbl[1]  = '{1'b1,1'b0,8'd0,4'd0,1'b0,1'b0,1'b0,1'b0,1'b0,8'd0};
        tbl[2]  = '{1'b0,1'b1,8'd1,4'd0,1'b0,1'b1,1'b1,1'b0,1'b0,8'd0};
        tbl[3]  = '{1'b0,1'b0,8'd0,4'd0,1'b0,1'b1,1'b1,1'b0,1'b0,8'd0};
        tbl[4]  = '{1'b0,1'b0,8'd0,4'd0,1'b0,1'b0,1'b1,1'b0,1'b0,8'd0};
        tbl[5]  = '{1'b0,1'b0,8'd0,4'd0,1'b0,1'b0,1'b0,1'b1,1'b1,8'd1};
        tbl[6]  = '{1'b0,1'b0,8'd0,4'd0,1'b0,1'b0,1'b0,1'b0,1'b1,8'd1};
        tbl[7]  = '{1'b0,1'b0,8'd0,4'd0,1'b1,1'b0,1'b0,1'b0,1'b1,8'd1};
        tbl[8]  = '{1'b1,1'b0,8'd0,4'd0,1'b0,1'b0,1'b0,1'b0,1'b0,8'd0};
        tbl[9]  = '{1'b0,1'b1,8'd0,4'd5,1'b0,1'b0,1'b0,1'b1,1'b0,8'd0};
        tbl[10] = '{1'b0,1'b0,8'd0,4'd0,1'b0,1'b0,1'b0,1'b0,1'b0,8'd0};
        tbl[11] = '{1'b0,1'b0,8'd0,4'd0,1'b0,1'b0,1'b0,1'b0,1'b0,8'd0};

        // Reset and single triplet.
        run_rows(0, 7);

        // Three triplets separated by two idle zeros.
        do_reset();
        exp3 = 13'b1100011000110;
        start = 1'b1; toggles = 8'd3; gap = 4'd2;
        tick();
        start = 1'b0;
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("s3_out%0d", i), 32'(out), 32'(exp3[12-i]));
            chk($sformatf("s3_busy%0d", i), 32'(busy), 32'd1);
            chk($sformatf("s3_done%0d", i), 32'(done), 32'd0);
            tick();
        end
        chk_all("s3_end", 1'b0, 1'b0, 1'b1, 1'b1, 8'd3);
        tick();
        chk_all("s3_idle", 1'b0, 1'b0, 1'b0, 1'b1, 8'd3);

        // Zero-length burst.
        run_rows(8, 11);

        // Abort during B2 of the second triplet.
        do_reset();
        exp5 = 6'b110110;
        start = 1'b1; toggles = 8'd5; gap = 4'd0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("s5_out%0d", i), 32'(out), 32'(exp5[5-i]));
            if (i == 4) abort = 1'b1;
            tick();
            abort = 1'b0;
        end
        chk_all("s5_end", 1'b0, 1'b0, 1'b1, 1'b0, 8'd2);
        tick();
        chk_all("s5_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);

        // Start while busy is ignored; reset in GAP.
        do_reset();
        start = 1'b1; toggles = 8'd3; gap = 4'd3;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk_all("s6_gap", 1'b0, 1'b1, 1'b0, 1'b1, 8'd1);
        start = 1'b1; toggles = 8'd7; gap = 4'd0;
        tick();
        start = 1'b0;
        chk_all("s6_ign", 1'b0, 1'b1, 1'b0, 1'b1, 8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all("s6_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        chk_all("s6_post", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
